// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
//   op_e    : operation encoding on the request op field
//   state_e : control FSM states
//   STEPS   : shift-add iterations per operation
//   magnitude() : absolute value of a word when it is treated as signed
package mul_pkg;

    localparam int unsigned STEPS = 32;

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhsu = 2'b10,
        OpMulhu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle of the sequential multiplier.
//   master : requester side (drives in_valid/op/rs1/rs2/flush/out_ready)
//   slave  : multiplier side (drives in_ready/out_valid/result/busy)
interface mul_seq_if #(
    parameter int unsigned XLEN = 32
) ();
    import mul_pkg::*;

    logic            in_valid;
    logic            in_ready;
    op_e             op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/mul_seq_fsm.sv
// Control FSM and step counter of the sequential multiplier.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid_i   : request present
//   flush_i      : abort in-flight operation
//   out_ready_i  : consumer takes result
//   in_ready_o   : idle, request can be accepted
//   out_valid_o  : result available
//   busy_o       : operation in flight or result pending
//   load_o       : capture operands, clear accumulator
//   step_o       : perform one shift-add step
//   finish_o     : apply sign correction, result becomes final
module mul_seq_fsm
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    input  logic flush_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic busy_o,
    output logic load_o,
    output logic step_o,
    output logic finish_o
);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    // Set once the counter has wrapped; the following cycle is the sign-correction cycle.
    logic       wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrap_d      = wrap_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        load_o      = 1'b0;
        step_o      = 1'b0;
        finish_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                // flush is ignored here, so a simultaneous request still goes in
                if (in_valid_i) begin
                    load_o  = 1'b1;
                    cnt_d   = 5'd0;
                    wrap_d  = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    cnt_d   = 5'd0;
                    wrap_d  = 1'b0;
                    state_d = StIdle;
                end else if (wrap_q) begin
                    finish_o = 1'b1;
                    wrap_d   = 1'b0;
                    state_d  = StDone;
                end else begin
                    step_o = 1'b1;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'(STEPS - 1)) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            StDone: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (flush_i || out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 shift-add multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to magnitudes on accept, multiplied unsigned one bit per
// cycle, and the 64-bit product is negated at the end when the signs differ.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_seq_if.slave   bus
);

    logic load, step, finish, out_valid;

    mul_seq_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .flush_i     (bus.flush),
        .out_ready_i (bus.out_ready),
        .in_ready_o  (bus.in_ready),
        .out_valid_o (out_valid),
        .busy_o      (bus.busy),
        .load_o      (load),
        .step_o      (step),
        .finish_o    (finish)
    );

    op_e               op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OpMul;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        // Carry out of the upper-half add is kept and shifted back in.
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        if (load) begin
            op_d     = bus.op;
            mcand_d  = magnitude(bus.rs1, (bus.op == OpMulh) || (bus.op == OpMulhsu));
            mplier_d = magnitude(bus.rs2, bus.op == OpMulh);
            unique case (bus.op)
                OpMulh:   neg_d = bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1];
                OpMulhsu: neg_d = bus.rs1[XLEN-1];
                default:  neg_d = 1'b0;
            endcase
            acc_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = {sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        end else if (finish && neg_q) begin
            acc_d = ~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.result    = !out_valid      ? '0 :
                           (op_q == OpMul) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_mul_seq;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_if #(.XLEN(32)) bus ();

    mul_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          with_flush;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consume results on handshake, and require result==0 when idle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%08h, expected no output at %0t",
                             bus.result, $time);
                end else begin
                    check("result", bus.result, exp_q.pop_front());
                end
            end else if (!bus.out_valid) begin
                check("result_zero_when_invalid", bus.result, 32'h0);
            end
        end
    end

    task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp, input bit with_flush);
        int k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'h1);
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.in_valid = 1'b1;
        bus.flush    = with_flush;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        // Disturb the request lines; the in-flight result must not change.
        bus.rs1      = $urandom;
        bus.rs2      = $urandom;
        bus.op       = op_e'(2'($urandom));
    endtask

    // Edges after accept until out_valid is seen (0 if it never came).
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t vecs[] = '{
        '{OpMul,    32'd7,        32'd6,        32'h0000002A, 1'b0},
        '{OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
        '{OpMul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
        '{OpMulh,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
        '{OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
        '{OpMulh,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b1},
        '{OpMul,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0},
        '{OpMulh,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0},
        '{OpMul,    32'd0,        32'd12345,    32'h00000000, 1'b0},
        '{OpMulhu,  32'h80000000, 32'd4,        32'h00000002, 1'b0},
        '{OpMulhsu, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0},
        '{OpMulhsu, 32'd2,        32'h80000000, 32'h00000001, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        bus.in_valid  = 1'b0;
        bus.op        = OpMul;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors with latency check
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, vecs[i].with_flush);
            wait_valid(lat);
            check("latency", 32'(lat), 32'd33);
            @(posedge clk);
            #1;
            check("idle_after_handshake", 32'(bus.in_ready), 32'h1);
        end

        // Back-pressure: result held while out_ready low
        bus.out_ready = 1'b0;
        issue(OpMul, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFE, 1'b0);
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'h1);
            check("stall_result", bus.result, 32'hFFFFFFFE);
            check("stall_no_accept", 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_idle_busy", 32'(bus.busy), 32'h0);
        check("stall_idle_ready", 32'(bus.in_ready), 32'h1);

        // Flush 10 cycles after accept
        issue(OpMul, 32'd9, 32'd9, 1'b0, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'h1);
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 32'(seen), 32'h0);
        issue(OpMul, 32'd3, 32'd5, 1'b1, 32'h0000000F, 1'b0);
        wait_valid(lat);
        check("post_flush_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;

        // Reset mid-operation
        issue(OpMul, 32'd100, 32'd100, 1'b0, 32'h0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_result", bus.result, 32'h0);
        bus.in_valid = 1'b1;
        bus.op       = OpMul;
        bus.rs1      = 32'd11;
        bus.rs2      = 32'd11;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_stale_valid", 32'(seen), 32'h0);
        issue(OpMulhu, 32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 1'b0);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit idle, can accept.
REQ-006 SHALL have port op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port rs1  input  32  multiplicand.
REQ-008 SHALL have port rs2  input  32  multiplier.
REQ-009 SHALL have port flush  input  1  abort in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  32  selected product word.
REQ-013 SHALL have port busy  output  1  high in BUSY or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1; on in_valid, capture op, operand magnitudes, result-sign flag, clear 64-bit accumulator and 5-bit counter, go to BUSY.
REQ-016 Signedness: MUL/MULHU both unsigned; MULH both signed; MULHSU rs1 signed, rs2 unsigned; magnitude = two's-complement negate when signed and MSB=1.
REQ-017 BUSY: one shift-add step per cycle: if multiplier LSB=1 add multiplicand into accumulator upper half, then shift {carry,acc} right 1; counter increments.
REQ-018 BUSY exits to DONE after exactly 32 steps (counter wraps 31->0); sign correction (64-bit negate if flag) applied on that transition.
REQ-019 Latency: accept at edge T -> out_valid high for the cycle following edge T+33.
REQ-020 DONE: out_valid=1; result = acc[31:0] for MUL, acc[63:32] otherwise; result stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1 -> IDLE next edge; no back-to-back accept in the handshake cycle (in_ready=0 in DONE).
REQ-022 flush=1 in BUSY or DONE -> IDLE next edge, out_valid=0 from that edge, result discarded; flush in IDLE ignored; flush has priority over out_ready and step logic.
REQ-023 flush and in_valid together in IDLE -> request accepted.
REQ-024 Operands 0 or op changes after accept SHALL NOT affect the in-flight result.
REQ-025 result SHALL read 0 whenever out_valid=0.

Reset
REQ-026 rst_n low SHALL force IDLE, counter 0, accumulator 0, out_valid 0, in_ready 1 (from reset release), busy 0, result 0, regardless of state mid-operation.
REQ-027 No request SHALL be accepted while rst_n is low.

Structure
REQ-028 Shared package mul_pkg SHALL hold op enum (MUL, MULH, MULHSU, MULHU), state enum, and constant STEPS=32.
REQ-029 FSM and counter SHALL be one sub-module mul_seq_fsm issuing load/step/finish enables to the datapath registers in mul_seq.

Verification
REQ-030 MUL 7 x 6 accepted at T -> out_valid after edge T+33, result 0x0000002A.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 MUL 0xFFFFFFFF x 2, out_ready held low 5 cycles in DONE -> result 0xFFFFFFFE stable all 5 cycles, IDLE one edge after out_ready=1.
REQ-034 flush 10 cycles after accept -> in_ready=1 next cycle, out_valid never asserts; following MUL 3 x 5 returns 0x0000000F.
REQ-035 rst_n low 20 cycles after accept -> all outputs at reset values immediately, no stale out_valid after release.
